current_protect_ctrl: RTL and testbench

- Overcurrent protection sequencer for one power stage, fed by the 12-bit current ADC sample stream (`current_b_out` + `sample_valid`).
- Enables the stage on request and debounces over-limit samples with hysteresis.
- On a trip: turns the stage off, waits a cooldown, auto-retries a bounded number of times, then latches lockout until software clears it.
- Sits between the ADC interface and the gate-driver enable.

---
 rtl/current_protect_ctrl.sv | 132 +++++++++++++
 tb/tb_current_protect_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/current_protect_ctrl.sv
// rtl/current_protect_ctrl.sv - overcurrent protection sequencer for one power stage
// Debounces hysteretic over-limit ADC samples, trips to cooldown with bounded auto-retry, then lockout.
module current_protect_ctrl #(
  parameter logic [11:0] CURRENT_MAX     = 12'd2500,
  parameter logic [11:0] CURRENT_RELEASE = 12'd2300,
  parameter int          TRIP_COUNT      = 16,
  parameter int          COOLDOWN_CYCLES = 5000,
  parameter int          MAX_RETRIES     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_req,
  input  logic        sample_valid,
  input  logic [11:0] current_b_out,
  input  logic        fault_clear,
  output logic        power_en,
  output logic        current_high,
  output logic        trip_pulse,
  output logic        lockout,
  output logic [3:0]  retry_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_OFF      = 2'd0,
    S_RUN      = 2'd1,
    S_COOLDOWN = 2'd2,
    S_LOCKOUT  = 2'd3
  } state_t;

  localparam int          TW          = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [TW-1:0] CD_LAST   = TW'(COOLDOWN_CYCLES - 1);
  localparam logic [7:0]  TRIP_LAST   = 8'(TRIP_COUNT - 1);
  localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRIES);

  state_t          r_state;
  state_t          w_state_next;
  logic            r_current_high;
  logic            r_trip_pulse;
  logic [3:0]      r_retry_cnt;
  logic [7:0]      r_over_cnt;
  logic [TW-1:0]   r_timer;

  logic w_over;
  logic w_healthy;
  logic w_trip;
  logic w_stay_run;
  logic w_stay_cd;

  assign w_over    = current_b_out >= CURRENT_MAX;
  assign w_healthy = current_b_out < CURRENT_RELEASE;
  // The edge accepting the TRIP_COUNT-th counted over-limit sample is the trip edge.
  assign w_trip    = (r_state == S_RUN) && sample_valid && w_over && (r_over_cnt >= TRIP_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_OFF: begin
        if (enable_req) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_trip)
          w_state_next = (r_retry_cnt < RETRY_LIMIT) ? S_COOLDOWN : S_LOCKOUT;
        else if (!enable_req)
          w_state_next = S_OFF;
      end
      S_COOLDOWN: begin
        if (r_timer == CD_LAST) w_state_next = enable_req ? S_RUN : S_OFF;
      end
      S_LOCKOUT: begin
        if (fault_clear) w_state_next = S_OFF;
      end
      default: w_state_next = S_OFF;
    endcase
  end

  assign w_stay_run = (r_state == S_RUN) && (w_state_next == S_RUN);
  assign w_stay_cd  = (r_state == S_COOLDOWN) && (w_state_next == S_COOLDOWN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_OFF;
      r_current_high <= 1'b0;
      r_trip_pulse   <= 1'b0;
      r_retry_cnt    <= 4'd0;
      r_over_cnt     <= 8'd0;
      r_timer        <= '0;
    end else begin
      r_state      <= w_state_next;
      r_trip_pulse <= w_trip;

      if (sample_valid) begin
        if (w_over)
          r_current_high <= 1'b1;
        else if (w_healthy)
          r_current_high <= 1'b0;
      end

      if (w_trip) begin
        if (r_retry_cnt != 4'hF) r_retry_cnt <= r_retry_cnt + 4'd1;
      end else if (fault_clear) begin
        r_retry_cnt <= 4'd0;
      end

      // Held at zero outside RUN so every entry into RUN starts a fresh debounce.
      if (w_stay_run) begin
        if (sample_valid) begin
          if (w_over) begin
            if (r_over_cnt != 8'hFF) r_over_cnt <= r_over_cnt + 8'd1;
          end else if (w_healthy) begin
            r_over_cnt <= 8'd0;
          end
        end
      end else begin
        r_over_cnt <= 8'd0;
      end

      if (w_stay_cd)
        r_timer <= r_timer + TW'(1);
      else
        r_timer <= '0;
    end
  end

  assign state        = r_state;
  assign power_en     = (r_state == S_RUN);
  assign lockout      = (r_state == S_LOCKOUT);
  assign current_high = r_current_high;
  assign trip_pulse   = r_trip_pulse;
  assign retry_cnt    = r_retry_cnt;

endmodule

// File: tb/tb_current_protect_ctrl.sv
// tb/tb_current_protect_ctrl.sv - self-checking bench for current_protect_ctrl
// Reference model pushes expected outputs per step; they are popped and checked after each edge.
module tb_current_protect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_req = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] current_b_out = 12'd0;
  logic        fault_clear = 1'b0;
  logic        power_en;
  logic        current_high;
  logic        trip_pulse;
  logic        lockout;
  logic [3:0]  retry_cnt;
  logic [1:0]  state;

  current_protect_ctrl #(
    .CURRENT_MAX(12'd2500),
    .CURRENT_RELEASE(12'd2300),
    .TRIP_COUNT(4),
    .COOLDOWN_CYCLES(10),
    .MAX_RETRIES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable_req(enable_req),
    .sample_valid(sample_valid),
    .current_b_out(current_b_out),
    .fault_clear(fault_clear),
    .power_en(power_en),
    .current_high(current_high),
    .trip_pulse(trip_pulse),
    .lockout(lockout),
    .retry_cnt(retry_cnt),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic       pe;
    logic       hi;
    logic       tp;
    logic       lo;
    logic [3:0] rc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  int m_state = 0;
  int m_high = 0;
  int m_retry = 0;
  int m_over = 0;
  int m_timer = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_power_en"}, 32'(power_en), 32'd0);
    check({tag, "_high"}, 32'(current_high), 32'd0);
    check({tag, "_trip"}, 32'(trip_pulse), 32'd0);
    check({tag, "_lockout"}, 32'(lockout), 32'd0);
    check({tag, "_retry"}, 32'(retry_cnt), 32'd0);
  endtask

  task automatic model_step(input logic en, input logic sv, input logic [11:0] cur, input logic fc);
    int   ns;
    bit   trip;
    bit   over;
    bit   healthy;
    exp_t e;
    over    = (cur >= 12'd2500);
    healthy = (cur < 12'd2300);
    trip    = 1'b0;
    ns      = m_state;
    if (m_state == 1 && sv && over && (m_over + 1 >= 4)) trip = 1'b1;
    case (m_state)
      0: if (en) ns = 1;
      1: if (trip) ns = (m_retry < 2) ? 2 : 3; else if (!en) ns = 0;
      2: if (m_timer == 9) ns = en ? 1 : 0;
      3: if (fc) ns = 0;
      default: ns = 0;
    endcase
    if (sv && over) m_high = 1;
    else if (sv && healthy) m_high = 0;
    if (trip) m_retry = (m_retry == 15) ? 15 : m_retry + 1;
    else if (fc) m_retry = 0;
    if (m_state == 1 && ns == 1) begin
      if (sv && over) m_over = (m_over == 255) ? 255 : m_over + 1;
      else if (sv && healthy) m_over = 0;
    end else begin
      m_over = 0;
    end
    m_timer = (m_state == 2 && ns == 2) ? m_timer + 1 : 0;
    m_state = ns;
    e.st = 2'(m_state);
    e.pe = (m_state == 1);
    e.hi = 1'(m_high);
    e.tp = trip;
    e.lo = (m_state == 3);
    e.rc = 4'(m_retry);
    q.push_back(e);
  endtask

  task automatic step(input logic en, input logic sv, input logic [11:0] cur, input logic fc);
    exp_t e;
    enable_req    = en;
    sample_valid  = sv;
    current_b_out = cur;
    fault_clear   = fc;
    model_step(en, sv, cur, fc);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("state", 32'(state), 32'(e.st));
    check("power_en", 32'(power_en), 32'(e.pe));
    check("current_high", 32'(current_high), 32'(e.hi));
    check("trip_pulse", 32'(trip_pulse), 32'(e.tp));
    check("lockout", 32'(lockout), 32'(e.lo));
    check("retry_cnt", 32'(retry_cnt), 32'(e.rc));
    sample_valid = 1'b0;
    fault_clear  = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    m_state = 0; m_high = 0; m_retry = 0; m_over = 0; m_timer = 0;
    enable_req = 1'b0; sample_valid = 1'b0; fault_clear = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // enable, then debounce broken by a healthy sample, then trip
    step(1, 0, 12'd0, 0);
    check("t1_power_en", 32'(power_en), 32'd1);
    repeat (3) step(1, 1, 12'd2600, 0);
    check("t2_no_trip", 32'(trip_pulse), 32'd0);
    step(1, 1, 12'd2000, 0);
    check("t2_high_cleared", 32'(current_high), 32'd0);
    repeat (4) step(1, 1, 12'd2600, 0);
    check("t2_trip", 32'(trip_pulse), 32'd1);
    check("t2_state", 32'(state), 32'd2);
    check("t2_retry", 32'(retry_cnt), 32'd1);

    repeat (9) step(1, 0, 12'd0, 0);
    check("t4_cd_last", 32'(state), 32'd2);
    step(1, 0, 12'd0, 0);
    check("t4_cd_exit", 32'(state), 32'd1);

    // in-band sample holds the debounce count
    step(1, 1, 12'd2600, 0);
    step(1, 1, 12'd2600, 0);
    step(1, 1, 12'd2400, 0);
    check("t3_hold_high", 32'(current_high), 32'd1);
    step(1, 1, 12'd2600, 0);
    step(1, 1, 12'd2600, 0);
    check("t3_trip", 32'(trip_pulse), 32'd1);

    for (int i = 0; i < 9; i++) step(1'(i % 2), 0, 12'd0, 0);
    step(1, 0, 12'd0, 0);
    repeat (4) step(1, 1, 12'd2600, 0);
    check("t4_lockout_state", 32'(state), 32'd3);
    check("t4_lockout_retry", 32'(retry_cnt), 32'd3);
    for (int i = 0; i < 5; i++) step(1'(i % 2), 1, 12'd2700, 0);
    check("t4_lockout_held", 32'(lockout), 32'd1);
    step(1, 0, 12'd0, 1);
    check("t4_clear_state", 32'(state), 32'd0);
    check("t4_clear_retry", 32'(retry_cnt), 32'd0);

    // trip beats a simultaneous enable drop
    step(1, 0, 12'd0, 0);
    repeat (3) step(1, 1, 12'd2600, 0);
    step(0, 1, 12'd2600, 0);
    check("t5_cooldown", 32'(state), 32'd2);
    repeat (10) step(0, 0, 12'd0, 0);
    check("t5_off", 32'(state), 32'd0);

    // fault_clear coincident with a trip: increment wins
    step(1, 0, 12'd0, 0);
    repeat (3) step(1, 1, 12'd2600, 0);
    step(1, 1, 12'd2600, 1);
    check("fc_trip_retry", 32'(retry_cnt), 32'd2);

    repeat (5) step(1, 0, 12'd0, 0);
    async_reset("rst_cd");

    step(1, 0, 12'd0, 0);
    repeat (3) step(1, 1, 12'd2600, 0);
    async_reset("rst_deb");

    step(1, 0, 12'd0, 0);
    repeat (3) step(1, 1, 12'd2600, 0);
    check("t6_no_early_trip", 32'(state), 32'd1);
    step(1, 1, 12'd2600, 0);
    check("t6_trip", 32'(trip_pulse), 32'd1);
    check("t6_retry", 32'(retry_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
